// File: rtl/tick_mon_pkg.sv
// Shared definitions for the tick period monitor and the clock-counter dividers it watches.
// State encoding is fixed so status decoders elsewhere can rely on it.
package tick_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int unsigned DEF_CW       = 32;
    localparam int unsigned DEF_MIN_PER  = 10;
    localparam int unsigned DEF_MAX_PER  = 12;
    localparam int unsigned DEF_LOCK_CNT = 4;
    localparam int unsigned DEF_TIMEOUT  = 64;

endpackage

// File: rtl/tick_edge_det.sv
// Rising-edge detector for the monitored tick level.
// With TICK_SYNC_EN defined the tick first passes a 2-flop synchronizer.
module tick_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_in,
    output logic rise
);

    logic tick_s;
    logic tick_d;

`ifdef TICK_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], tick_in};
        end
    end

    assign tick_s = sync[1];
`else
    assign tick_s = tick_in;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_d <= 1'b0;
        end else begin
            tick_d <= tick_s;
        end
    end

    assign rise = tick_s & ~tick_d;

endmodule

// File: rtl/tick_period_mon.sv
// Measures clk-cycle period between tick rising edges, checks it against a window,
// declares lock after LOCK_CNT good periods and flags loss of tick. Optional: TICK_SYNC_EN.
module tick_period_mon
    import tick_mon_pkg::*;
#(
    parameter int unsigned CW       = DEF_CW,
    parameter int unsigned MIN_PER  = DEF_MIN_PER,
    parameter int unsigned MAX_PER  = DEF_MAX_PER,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          tick_in,
    output logic [CW-1:0] period,
    output logic          period_vld,
    output logic          range_err,
    output logic          timeout,
    output logic          locked
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);

    localparam logic [CW-1:0] MinC     = CW'(MIN_PER);
    localparam logic [CW-1:0] MaxC     = CW'(MAX_PER);
    localparam logic [CW-1:0] TimeoutC = CW'(TIMEOUT);
    localparam logic [GW-1:0] LockC    = GW'(LOCK_CNT);

    state_e        state;
    logic [CW-1:0] cnt;
    logic [GW-1:0] good;
    logic [GW-1:0] good_inc;
    logic          rise;
    logic          in_range;

    tick_edge_det u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .tick_in (tick_in),
        .rise    (rise)
    );

    assign in_range = (cnt >= MinC) && (cnt <= MaxC);
    assign good_inc = good + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            good       <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            range_err  <= 1'b0;
            timeout    <= 1'b0;
            locked     <= 1'b0;
        end else begin
            period_vld <= 1'b0;
            range_err  <= 1'b0;
            timeout    <= 1'b0;

            if (rise) begin
                cnt <= CW'(1);
            end else if (state != ST_IDLE && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_ACQ;
                        good  <= '0;
                    end
                end
                ST_ACQ, ST_LOCKED: begin
                    // A rise landing on cnt==TIMEOUT is a measurement, not a timeout.
                    if (rise) begin
                        period     <= cnt;
                        period_vld <= 1'b1;
                        if (in_range) begin
                            if (state == ST_ACQ) begin
                                good <= good_inc;
                                if (good_inc >= LockC) begin
                                    state  <= ST_LOCKED;
                                    locked <= 1'b1;
                                end
                            end
                        end else begin
                            range_err <= 1'b1;
                            good      <= '0;
                            state     <= ST_ACQ;
                            locked    <= 1'b0;
                        end
                    end else if (cnt == TimeoutC) begin
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                        good    <= '0;
                        cnt     <= '0;
                        locked  <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    good   <= '0;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_period_mon.sv
// Scoreboard bench for tick_period_mon: directed edge gaps with hand-computed results.
// Build with TICK_SYNC_EN defined to exercise the synchronized variant (2 extra cycles).
module tb_tick_period_mon;

    localparam int CW = 32;
`ifdef TICK_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          tick_in;
    logic [CW-1:0] period;
    logic          period_vld;
    logic          range_err;
    logic          timeout;
    logic          locked;

    typedef struct {
        bit is_to;
        int per;
        bit err;
        bit lck;
        int cyc;
    } exp_t;

    typedef struct {
        bit op;    // 0: edge after gap, 1: stop tick and expect timeout
        int gap;
        bit vld;
        int per;
        bit err;
        bit lck;
    } row_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   last_k = 0;

    tick_period_mon dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick_in    (tick_in),
        .period     (period),
        .period_vld (period_vld),
        .range_err  (range_err),
        .timeout    (timeout),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops one expectation per reported event.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (period_vld || timeout) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: vld=%0b timeout=%0b period=%0d, none expected",
                             period_vld, timeout, period);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("event_timeout", longint'(timeout), longint'(e.is_to));
                    chk("event_vld", longint'(period_vld), longint'(!e.is_to));
                    chk("event_cycle", cyc, e.cyc);
                    chk("period", period, e.per);
                    chk("range_err", longint'(range_err), longint'(e.err));
                    chk("locked", longint'(locked), longint'(e.lck));
                end
            end else if (range_err) begin
                checks++;
                errors++;
                $display("FAIL stray_range_err: got 1 expected 0 (cycle %0d)", cyc);
            end
        end
    end

    task automatic edge_after(input int gap, input bit vld, input int per, input bit err,
                              input bit lck);
        exp_t e;
        tick_in = 1'b0;
        repeat (gap - 1) begin
            @(posedge clk);
            #1;
        end
        tick_in = 1'b1;
        last_k  = cyc + 1;
        if (vld) begin
            e.is_to = 1'b0;
            e.per   = per;
            e.err   = err;
            e.lck   = lck;
            e.cyc   = last_k + LAT;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_timeout(input int per);
        exp_t e;
        tick_in = 1'b0;
        e.is_to = 1'b1;
        e.per   = per;
        e.err   = 1'b0;
        e.lck   = 1'b0;
        e.cyc   = last_k + LAT + 64;
        q.push_back(e);
        repeat (75) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_vld"}, longint'(period_vld), 0);
        chk({tag, "_range_err"}, longint'(range_err), 0);
        chk({tag, "_timeout"}, longint'(timeout), 0);
        chk({tag, "_locked"}, longint'(locked), 0);
    endtask

    row_t tab[26] = '{
        '{0, 3, 0, 0, 0, 0},      // first edge: IDLE -> ACQ, nothing reported
        '{0, 11, 1, 11, 0, 0},
        '{0, 11, 1, 11, 0, 0},
        '{0, 11, 1, 11, 0, 0},
        '{0, 11, 1, 11, 0, 1},    // 4th good period: locked
        '{0, 11, 1, 11, 0, 1},
        '{0, 15, 1, 15, 1, 0},    // out of range: back to ACQ
        '{0, 11, 1, 11, 0, 0},
        '{0, 11, 1, 11, 0, 0},
        '{0, 11, 1, 11, 0, 0},
        '{0, 11, 1, 11, 0, 1},
        '{1, 0, 0, 11, 0, 0},     // tick stops: timeout, period holds 11
        '{0, 3, 0, 0, 0, 0},
        '{0, 11, 1, 11, 0, 0},
        '{0, 11, 1, 11, 0, 0},
        '{0, 11, 1, 11, 0, 0},
        '{0, 11, 1, 11, 0, 1},
        '{0, 10, 1, 10, 0, 1},
        '{0, 12, 1, 12, 0, 1},
        '{0, 9, 1, 9, 1, 0},
        '{0, 13, 1, 13, 1, 0},
        '{0, 64, 1, 64, 1, 0},    // edge exactly at cnt==64: measured, not a timeout
        '{0, 10, 1, 10, 0, 0},
        '{0, 12, 1, 12, 0, 0},
        '{0, 11, 1, 11, 0, 0},
        '{0, 11, 1, 11, 0, 1}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        tick_in = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            tick_in = ~tick_in;
        end
        chk_cleared("reset_hold");
        tick_in = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        foreach (tab[i]) begin
            if (tab[i].op) expect_timeout(tab[i].per);
            else edge_after(tab[i].gap, tab[i].vld, tab[i].per, tab[i].err, tab[i].lck);
        end

        // Async reset mid-period while locked, checked before any further clock edge.
        tick_in = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_locked", longint'(locked), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_cleared("async_reset");
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        edge_after(3, 1'b0, 0, 1'b0, 1'b0);
        edge_after(11, 1'b1, 11, 1'b0, 1'b0);
        edge_after(12, 1'b1, 12, 1'b0, 1'b0);
        tick_in = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        chk("pending_expectations", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
